// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the sram32x64 two-requester controller.
// Merge helpers operate on the widest supported word; callers size-cast in and out.
package sram_ctrl_pkg;

  typedef enum logic {IDLE, RMW_WR} state_t;

  localparam int unsigned MAX_DW = 64;
  localparam int unsigned MAX_BW = MAX_DW / 8;

  localparam logic [MAX_BW-1:0] BSTRB_FULL = '1;

  // Per-byte select: strobed bytes come from new data, others from the old word.
  function automatic logic [MAX_DW-1:0] byte_merge(
    input logic [MAX_DW-1:0] wdata,
    input logic [MAX_DW-1:0] old,
    input logic [MAX_BW-1:0] bstrb
  );
    logic [MAX_DW-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < MAX_BW; k++) begin
      r[8*k +: 8] = bstrb[k] ? wdata[8*k +: 8] : old[8*k +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sram32x64_ctrl_if.sv
// Request/response bus between two requesters and the SRAM controller.
interface sram32x64_ctrl_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 64
);
  logic [1:0]              req_valid;
  logic [1:0]              req_ready;
  logic [1:0]              req_we;
  logic [1:0][AW-1:0]      req_addr;
  logic [1:0][DW-1:0]      req_wdata;
  logic [1:0][DW/8-1:0]    req_bstrb;
  logic [1:0]              rsp_valid;
  logic [DW-1:0]           rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_bstrb,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_bstrb,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves to the loser after each grant.
module sram_rr_arb2 (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] gnt
);
  logic rr_ptr;

  always_comb begin
    gnt = '0;
    if (en) begin
      if (valid[0] && valid[1]) gnt[rr_ptr] = 1'b1;
      else                      gnt = valid;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     rr_ptr <= 1'b0;
    else if (|gnt) rr_ptr <= gnt[0];
  end
endmodule

// File: rtl/sram32x64_ctrl.sv
// Shares one single-port sram32x64 between two requesters with round-robin
// arbitration, fixed-latency responses and read-modify-write for partial writes.
module sram32x64_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 64
) (
  input  logic                clk,
  input  logic                rstn,
  sram32x64_ctrl_if.slave     bus,
  output logic                sram_cs,
  output logic                sram_we,
  output logic [AW-1:0]       sram_a,
  output logic [DW-1:0]       sram_di,
  input  logic [DW-1:0]       sram_do
);
  localparam int unsigned BW = DW / 8;

  state_t state, state_nxt;

  logic [1:0]    gnt;
  logic          acc, sel_id, sel_we;
  logic          is_full, is_part;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [BW-1:0] sel_bstrb;

  logic          rmw_id;
  logic [AW-1:0] rmw_addr;
  logic [DW-1:0] rmw_wdata;
  logic [BW-1:0] rmw_bstrb;
  logic [1:0]    rsp_valid_q;
  logic          rsp_rd_q;
  logic [MAX_DW-1:0] merged_full;
  logic [DW-1:0] merged;

  // Gating with rstn keeps every output quiet while reset is held.
  sram_rr_arb2 u_arb (
    .clk   (clk),
    .rstn  (rstn),
    .en    ((state == IDLE) && rstn),
    .valid (bus.req_valid),
    .gnt   (gnt)
  );

  assign bus.req_ready = gnt;
  assign acc       = |gnt;
  assign sel_id    = gnt[1];
  assign sel_we    = bus.req_we[sel_id];
  assign sel_addr  = bus.req_addr[sel_id];
  assign sel_wdata = bus.req_wdata[sel_id];
  assign sel_bstrb = bus.req_bstrb[sel_id];
  assign is_full   = sel_we && (sel_bstrb == BSTRB_FULL[BW-1:0]);
  assign is_part   = sel_we && !is_full && (sel_bstrb != '0);

  assign merged_full = byte_merge(MAX_DW'(rmw_wdata), MAX_DW'(sram_do), MAX_BW'(rmw_bstrb));
  assign merged      = merged_full[DW-1:0];

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rd_q ? sram_do : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc && is_part) state_nxt = RMW_WR;
      RMW_WR:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sram_cs = 1'b0;
    sram_we = 1'b0;
    sram_a  = '0;
    sram_di = '0;
    case (state)
      IDLE: begin
        if (acc && (!sel_we || is_full || is_part)) begin
          sram_cs = 1'b1;
          sram_a  = sel_addr;
          if (is_full) begin
            sram_we = 1'b1;
            sram_di = sel_wdata;
          end
        end
      end
      RMW_WR: begin
        sram_cs = 1'b1;
        sram_we = 1'b1;
        sram_a  = rmw_addr;
        sram_di = merged;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_valid_q <= '0;
      rsp_rd_q    <= 1'b0;
      rmw_id      <= 1'b0;
      rmw_addr    <= '0;
      rmw_wdata   <= '0;
      rmw_bstrb   <= '0;
    end else begin
      rsp_valid_q <= '0;
      rsp_rd_q    <= 1'b0;
      if (state == RMW_WR) begin
        rsp_valid_q[rmw_id] <= 1'b1;
      end else if (acc && !is_part) begin
        rsp_valid_q[sel_id] <= 1'b1;
        rsp_rd_q            <= !sel_we;
      end
      if (acc && is_part) begin
        rmw_id    <= sel_id;
        rmw_addr  <= sel_addr;
        rmw_wdata <= sel_wdata;
        rmw_bstrb <= sel_bstrb;
      end
    end
  end
endmodule

// File: tb/tb_sram32x64_ctrl.sv
// Self-checking bench for sram32x64_ctrl with a behavioural SRAM and reference memory.
module tb_sram32x64_ctrl;
  logic        clk;
  logic        rstn;
  logic        sram_cs, sram_we;
  logic [4:0]  sram_a;
  logic [63:0] sram_di, sram_do;

  int checks   = 0;
  int failures = 0;
  int cs_cycles = 0;
  int both_rsp  = 0;

  logic [63:0] sram_mem [32];
  logic [63:0] ref_mem  [32];

  sram32x64_ctrl_if #(.AW(5), .DW(64)) bus ();

  sram32x64_ctrl #(.AW(5), .DW(64)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .bus     (bus),
    .sram_cs (sram_cs),
    .sram_we (sram_we),
    .sram_a  (sram_a),
    .sram_di (sram_di),
    .sram_do (sram_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sram32x64 behaviour: synchronous write, registered read data.
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) sram_mem[sram_a] <= sram_di;
      else         sram_do <= sram_mem[sram_a];
    end
  end

  always @(negedge clk) begin
    if (sram_cs === 1'b1)           cs_cycles++;
    if (bus.rsp_valid === 2'b11)    both_rsp++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                        input logic [7:0] bs);
    logic [63:0] m;
    for (int k = 0; k < 8; k++) m[k*8 +: 8] = {8{bs[k]}};
    return (wd & m) | (old & ~m);
  endfunction

  task automatic set_req(input int unsigned id, input logic we, input logic [4:0] addr,
                         input logic [63:0] wd, input logic [7:0] bs);
    bus.req_valid[id] = 1'b1;
    bus.req_we[id]    = we;
    bus.req_addr[id]  = addr;
    bus.req_wdata[id] = wd;
    bus.req_bstrb[id] = bs;
  endtask

  // One isolated transaction: grant, SRAM drive, response latency and data.
  task automatic do_single(input string tag, input int unsigned id, input logic we,
                           input logic [4:0] addr, input logic [63:0] wd, input logic [7:0] bs);
    int unsigned n;
    logic part;
    logic [63:0] exp;
    @(posedge clk); #1;
    set_req(id, we, addr, wd, bs);
    n = 0;
    @(negedge clk);
    while (!bus.req_ready[id] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_grant"}, 64'(bus.req_ready[id]), 64'd1);
    if (bus.req_ready[id] !== 1'b1) begin
      bus.req_valid[id] = 1'b0;
      return;
    end
    chk({tag, "_cs"}, 64'(sram_cs), 64'(!we || bs != 8'h00));
    chk({tag, "_we"}, 64'(sram_we), 64'(we && bs == 8'hFF));
    part = we && bs != 8'h00 && bs != 8'hFF;
    exp  = we ? 64'h0 : ref_mem[addr];
    if (we) ref_mem[addr] = merge(ref_mem[addr], wd, bs);
    @(posedge clk); #1;
    bus.req_valid[id] = 1'b0;
    if (part) begin
      @(negedge clk);
      chk({tag, "_rmw_we"}, 64'(sram_we), 64'd1);
      chk({tag, "_rmw_di"}, sram_di, ref_mem[addr]);
      chk({tag, "_rmw_rdy"}, 64'(bus.req_ready), 64'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(2'b01 << id));
    chk({tag, "_rsp_rdata"}, bus.rsp_rdata, exp);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 1'b0;
    bus.req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  initial begin
    int c0;
    logic [63:0] wd;
    logic [7:0]  bs;
    rstn = 1'b0;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_bstrb = '0;

    // Reset values
    @(negedge clk);
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp",   64'(bus.rsp_valid), 64'd0);
    chk("rst_cs",    64'(sram_cs), 64'd0);
    chk("rst_we",    64'(sram_we), 64'd0);
    chk("rst_a",     64'(sram_a), 64'd0);
    chk("rst_di",    sram_di, 64'd0);
    @(posedge clk); #1 rstn = 1'b1;

    // Preload every word; word 7 is zero for the reset-mid-RMW case
    for (int i = 0; i < 32; i++) begin
      ref_mem[i] = 'x;
      wd = (i == 7) ? 64'h0 : {$urandom, $urandom};
      do_single("preload", i % 2, 1'b1, 5'(i), wd, 8'hFF);
    end

    // Full write then read back
    c0 = cs_cycles;
    do_single("wr3", 0, 1'b1, 5'd3, 64'h1122334455667788, 8'hFF);
    do_single("rd3", 0, 1'b0, 5'd3, 64'h0, 8'h00);
    chk("wr_rd_cs_cycles", 64'(cs_cycles - c0), 64'd2);

    // Partial write with a read presented right behind it
    @(posedge clk); #1;
    set_req(1, 1'b1, 5'd3, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
    @(negedge clk);
    chk("pw_grant", 64'(bus.req_ready), 64'b10);
    @(posedge clk); #1;
    set_req(1, 1'b0, 5'd3, 64'h0, 8'h00);
    @(negedge clk);
    chk("pw_t1_ready", 64'(bus.req_ready), 64'd0);
    chk("pw_t1_we",    64'(sram_we), 64'd1);
    chk("pw_t1_di",    sram_di, merge(64'h1122334455667788, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F));
    chk("pw_t1_rsp",   64'(bus.rsp_valid), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("pw_t2_rsp",   64'(bus.rsp_valid), 64'b10);
    chk("pw_t2_rdata", bus.rsp_rdata, 64'h0);
    chk("pw_t2_grant", 64'(bus.req_ready), 64'b10);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    chk("pw_rd_rsp",   64'(bus.rsp_valid), 64'b10);
    chk("pw_rd_rdata", bus.rsp_rdata, 64'h11223344AAAAAAAA);
    ref_mem[3] = 64'h11223344AAAAAAAA;

    // Null write leaves memory untouched
    c0 = cs_cycles;
    do_single("nullwr", 0, 1'b1, 5'd3, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00);
    chk("nullwr_cs_cycles", 64'(cs_cycles - c0), 64'd0);
    do_single("nullwr_rd", 0, 1'b0, 5'd3, 64'h0, 8'h00);

    // Fairness with both requesters reading continuously after reset
    do_reset();
    set_req(0, 1'b0, 5'd1, 64'h0, 8'h00);
    set_req(1, 1'b0, 5'd2, 64'h0, 8'h00);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c < 6) chk("rr_grant", 64'(bus.req_ready), 64'(2'b01 << (c % 2)));
      if (c > 0) begin
        chk("rr_rsp",   64'(bus.rsp_valid), 64'(2'b01 << ((c - 1) % 2)));
        chk("rr_rdata", bus.rsp_rdata, ((c - 1) % 2 == 1) ? ref_mem[2] : ref_mem[1]);
      end
      @(posedge clk); #1;
      if (c == 5) bus.req_valid = '0;
    end

    // Reset asserted while the RMW write cycle is in flight
    set_req(0, 1'b1, 5'd7, 64'h5555_6666_7777_8888, 8'h3C);
    @(negedge clk);
    chk("rmwrst_grant", 64'(bus.req_ready), 64'b01);
    @(posedge clk); #1;
    bus.req_valid = '0;
    chk("rmwrst_we_before", 64'(sram_we), 64'd1);
    rstn = 1'b0;
    #1;
    chk("rmwrst_we",    64'(sram_we), 64'd0);
    chk("rmwrst_cs",    64'(sram_cs), 64'd0);
    chk("rmwrst_ready", 64'(bus.req_ready), 64'd0);
    chk("rmwrst_rsp",   64'(bus.rsp_valid), 64'd0);
    chk("rmwrst_a",     64'(sram_a), 64'd0);
    chk("rmwrst_di",    sram_di, 64'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rmwrst_no_rsp", 64'(bus.rsp_valid), 64'd0);
    end
    @(posedge clk); #1 rstn = 1'b1;
    do_single("rmwrst_rd7", 0, 1'b0, 5'd7, 64'h0, 8'h00);

    // Back-to-back reads over the whole address range
    for (int i = 0; i < 33; i++) begin
      @(posedge clk); #1;
      if (i < 32) set_req(0, 1'b0, 5'(i), 64'h0, 8'h00);
      else        bus.req_valid = '0;
      @(negedge clk);
      if (i < 32) chk("b2b_ready", 64'(bus.req_ready), 64'b01);
      if (i > 0) begin
        chk("b2b_rsp",   64'(bus.rsp_valid), 64'b01);
        chk("b2b_rdata", bus.rsp_rdata, ref_mem[i-1]);
      end
    end

    // Randomised single transactions against the reference memory
    for (int i = 0; i < 40; i++) begin
      case ($urandom % 4)
        0:       bs = 8'hFF;
        1:       bs = 8'h00;
        default: bs = 8'($urandom);
      endcase
      do_single("rand", $urandom % 2, 1'($urandom), 5'($urandom), {$urandom, $urandom}, bs);
    end

    chk("rsp_onehot", 64'(both_rsp), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sram32x64_ctrl.md
Name: sram32x64_ctrl

Overview:
- Two-requester controller that shares one sram32x64 instance.
- SRAM behaviour it drives:
  - single port;
  - CS/WE/A/DI sampled at posedge;
  - DO registered, so valid in the cycle after the access;
  - no byte enables.
- Provides round-robin arbitration, valid/ready request handshake, fixed-latency responses, and read-modify-write (RMW) for partial-byte writes.
- Used as a shared scratch/tag-store front end (e.g. I-side and D-side).

Parameters:
- AW, 5, address width; must match the SRAM.
- DW, 64, data width; multiple of 8; byte-strobe width is DW/8.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester grant; the request is accepted when valid&ready.
- req_we  in  2  1 = write.
- req_addr  in  2xAW  word address.
- req_wdata  in  2xDW  write data.
- req_bstrb  in  2xDW/8  byte strobes; ignored for reads.
- rsp_valid  out  2  one-cycle response pulse.
- rsp_rdata  out  DW  read data, shared by both requesters; qualified by rsp_valid.
- sram_cs  out  1  to SRAM CS.
- sram_we  out  1  to SRAM WE.
- sram_a  out  AW  to SRAM A.
- sram_di  out  DW  to SRAM DI.
- sram_do  in  DW  from SRAM DO.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, sram_cs=0, sram_we=0, sram_a=0, sram_di=0, state=IDLE, rr_ptr=0 (requester 0 has priority).
- FSM states:
  - IDLE: may accept a request.
  - RMW_WR: second cycle of a partial write; accepts nothing.
- Arbitration (IDLE only):
  - req_ready is combinational from req_valid and rr_ptr.
  - At most one bit of req_ready is high.
  - If both requesters are valid, the one at rr_ptr wins.
  - rr_ptr toggles to the non-winner after every accepted request.
  - A single valid requester is granted regardless of rr_ptr.
- Sequencing by accepted request type:
  - Read:
    - Same cycle T: sram_cs=1, sram_we=0, sram_a=addr.
    - T+1: rsp_valid[id]=1, rsp_rdata=sram_do.
    - Back-to-back reads give a throughput of 1 per cycle.
  - Full write (bstrb all ones):
    - Cycle T: sram_cs=1, sram_we=1, sram_di=wdata.
    - T+1: rsp_valid[id]=1, rsp_rdata=0.
  - Null write (bstrb=0):
    - No SRAM access (sram_cs=0).
    - T+1: rsp_valid[id]=1, rsp_rdata=0.
  - Partial write:
    - Cycle T: SRAM read of addr; latch id, addr, wdata and bstrb; go to RMW_WR.
    - T+1: req_ready=0; sram_cs=1, sram_we=1, sram_a=latched addr; sram_di[byte k] = bstrb[k] ? wdata[byte k] : sram_do[byte k]; return to IDLE.
    - T+2: rsp_valid[id]=1, rsp_rdata=0.
- Registered state: rsp_valid, the response id and the response kind (read/write) are registered. rsp_rdata is combinational from sram_do for reads and 0 for writes.
- SRAM drive when idle: sram_cs=0 and sram_we=0 whenever no access is issued. sram_a and sram_di are don't-care while cs=0 but must not be X.
- Ordering and coherency:
  - A request accepted at T+2 after an RMW sees the merged data, because the write commits at the T+1 edge.
  - Responses return in acceptance order.
  - rsp_valid is never high for both requesters in the same cycle.
- Requester rules:
  - The request must be held stable while valid && !ready.
  - The controller tolerates valid dropping before a grant; no request is lost or duplicated.
- Reset mid-RMW: asynchronous reset forces IDLE and sram_cs=0. The partial write is abandoned (SRAM not written) and no response is issued.
- Address: no wrap logic needed; addr is AW bits, so all 32 words are accessible.

Decomposition:
- Package sram_ctrl_pkg holds:
  - state enum {IDLE, RMW_WR};
  - BSTRB_FULL constant;
  - the byte-merge function (per-byte select on strobe).
- Submodule sram_rr_arb2: 2-way round-robin arbiter.
  - Inputs: valid[1:0], en, clk, rstn.
  - Outputs: gnt[1:0].
  - Owns rr_ptr.

Test Plan:
- Write then read back: req0 write addr=3, wdata=64'h1122334455667788, bstrb=FF, then req0 read addr=3 → write rsp at T+1 with rdata=0; read rsp at T+1 of the read with rdata=64'h1122334455667788; sram_cs high exactly 2 cycles.
- Partial write merge: after the above, req1 write addr=3, wdata=64'hAAAA_AAAA_AAAA_AAAA, bstrb=8'h0F, then read addr=3 → req_ready low the cycle after acceptance; rsp at T+2; readback 64'h11223344AAAAAAAA.
- Arbitration fairness: both requesters hold valid reads for 6 cycles after reset → grants alternate 0,1,0,1,0,1; rsp_valid one-hot each cycle with the matching id.
- Null write: req0 write bstrb=0 → sram_cs stays 0; rsp_valid[0] at T+1; SRAM contents unchanged on readback.
- Reset mid-RMW: issue a partial write to addr=7 (pre-filled 64'h0), assert rstn=0 during RMW_WR → sram_we deasserts immediately; no rsp; all outputs at reset values; after release, read addr=7 returns 64'h0.
- Back-to-back pipelined reads: req0 reads addrs 0..31 continuously → 32 consecutive rsp_valid[0] pulses with matching data, no bubbles.
